// File: rtl/series_ctrl_pkg.sv
// rtl/series_ctrl_pkg.sv - shared types and constants for the series-evaluation controller
package series_ctrl_pkg;

    localparam int NIB_W = 4;
    localparam int X_W   = 8;
    localparam int VAL_W = 16;

    localparam logic [VAL_W-1:0] T_ONE = 16'h0100;

    typedef enum logic [3:0] {
        S_IDLE,
        S_LOAD_N,
        S_LOAD_XH,
        S_LOAD_XL,
        S_INIT,
        S_CHECK,
        S_ACC,
        S_MUL,
        S_DONE
    } state_e;

endpackage

// File: rtl/series_ctrl.sv
// rtl/series_ctrl.sv - control FSM driving the geometric-series datapath and holding its result
module series_ctrl
    import series_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             nEqual,
    input  logic [VAL_W-1:0] adderOut,
    output logic             nRegEn,
    output logic             xRegEn,
    output logic             init_t,
    output logic             init_r,
    output logic             initCount,
    output logic             ld_r,
    output logic             ld_t,
    output logic             enCount,
    output logic             busy,
    output logic             done,
    output logic [VAL_W-1:0] result
);

    state_e             state_q, state_d;
    logic [VAL_W-1:0]   result_q, result_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        case (state_q)
            S_IDLE:    if (start)    state_d = S_LOAD_N;
            S_LOAD_N:  if (in_valid) state_d = S_LOAD_XH;
            S_LOAD_XH: if (in_valid) state_d = S_LOAD_XL;
            S_LOAD_XL: if (in_valid) state_d = S_INIT;
            S_INIT:                  state_d = S_CHECK;
            // T+R at this point already includes the current term, so it is the final sum
            S_CHECK: begin
                if (nEqual) begin
                    result_d = adderOut;
                    state_d  = S_DONE;
                end else begin
                    state_d  = S_ACC;
                end
            end
            S_ACC:                   state_d = S_MUL;
            S_MUL:                   state_d = S_CHECK;
            S_DONE:                  state_d = S_IDLE;
            default:                 state_d = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        nRegEn    = 1'b0;
        xRegEn    = 1'b0;
        init_t    = 1'b0;
        init_r    = 1'b0;
        initCount = 1'b0;
        ld_r      = 1'b0;
        ld_t      = 1'b0;
        enCount   = 1'b0;
        done      = 1'b0;
        busy      = (state_q != S_IDLE) && (state_q != S_DONE);
        case (state_q)
            S_LOAD_N: begin
                in_ready = 1'b1;
                nRegEn   = in_valid;
            end
            S_LOAD_XH, S_LOAD_XL: begin
                in_ready = 1'b1;
                xRegEn   = in_valid;
            end
            S_INIT: begin
                init_t    = 1'b1;
                init_r    = 1'b1;
                initCount = 1'b1;
            end
            S_ACC:  ld_r = 1'b1;
            S_MUL: begin
                ld_t    = 1'b1;
                enCount = 1'b1;
            end
            S_DONE: done = 1'b1;
            default: ;
        endcase
    end

    assign result = result_q;

endmodule
